// File: rtl/id_decode_pipe.sv
// Decode stage: register file, opcode decode, load-use stall, two-word immediates and
// interrupt micro-op sequencing behind a registered ID/EX stage. Optional macro: REG_BYPASS_EN.
module id_decode_pipe #(
  parameter int WIDTH = 16,
  parameter int NREGS = 8,
  localparam int REG_AW = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [WIDTH-1:0]  in_instr,
  output logic              in_ready,
  input  logic              flush,
  input  logic              int_req,
  output logic              int_ack,
  input  logic              wb_en,
  input  logic [REG_AW-1:0] wb_addr,
  input  logic [WIDTH-1:0]  wb_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [4:0]        out_op,
  output logic [WIDTH-1:0]  out_op1,
  output logic [WIDTH-1:0]  out_op2,
  output logic [WIDTH-1:0]  out_imm,
  output logic [REG_AW-1:0] out_dst,
  output logic              out_regwr,
  output logic              out_memr,
  output logic              out_memwr
);

  localparam int HDR_W = 5 + 2 * REG_AW;

  typedef enum logic [1:0] {RUN, IMM, INT1, INT2} state_t;

  typedef struct packed {
    logic              valid;
    logic [4:0]        op;
    logic [WIDTH-1:0]  op1;
    logic [WIDTH-1:0]  op2;
    logic [WIDTH-1:0]  imm;
    logic [REG_AW-1:0] dst;
    logic              regwr;
    logic              memr;
    logic              memwr;
  } ex_t;

  function automatic logic [4:0] hdr_op(input logic [HDR_W-1:0] h);
    return h[HDR_W-1 -: 5];
  endfunction

  function automatic logic [REG_AW-1:0] hdr_rs(input logic [HDR_W-1:0] h);
    return h[HDR_W-6 -: REG_AW];
  endfunction

  function automatic logic [REG_AW-1:0] hdr_rd(input logic [HDR_W-1:0] h);
    return h[REG_AW-1:0];
  endfunction

  // Returns {regwr, memr, memwr}.
  function automatic logic [2:0] dec_flags(input logic [4:0] op);
    logic [2:0] f;
    f = 3'b000;
    case (op[4:3])
      2'b00: f = 3'b100;
      2'b01: begin
        if (op == 5'b01000) f = 3'b110;
        else if (op == 5'b01001) f = 3'b001;
      end
      2'b10: f = 3'b100;
      default: f = 3'b000;
    endcase
    return f;
  endfunction

  function automatic ex_t mk_ex(input logic [4:0] op, input logic [WIDTH-1:0] op1,
                                input logic [WIDTH-1:0] op2, input logic [WIDTH-1:0] imm,
                                input logic [REG_AW-1:0] dst);
    ex_t e;
    logic [2:0] f;
    f       = dec_flags(op);
    e.valid = 1'b1;
    e.op    = op;
    e.op1   = op1;
    e.op2   = op2;
    e.imm   = imm;
    e.dst   = dst;
    e.regwr = f[2];
    e.memr  = f[1];
    e.memwr = f[0];
    return e;
  endfunction

  state_t            state_q, state_d, state_eff;
  logic [HDR_W-1:0]  first_q, first_d, in_hdr, src_hdr;
  logic              pending_q, pending_d;
  logic              last_memr_q, last_memr_d;
  logic [REG_AW-1:0] last_dst_q, last_dst_d;
  logic [WIDTH-1:0]  regs_q [NREGS];
  logic [WIDTH-1:0]  regs_d [NREGS];
  ex_t               ex_q, ex_d;
  logic              int_ack_q, int_ack_d;
  logic              adv, stall, take, in_rdy, accept, uses_rd;
  logic [4:0]        in_op;
  logic [WIDTH-1:0]  rs_val, rd_val;

  assign in_hdr  = in_instr[WIDTH-1 -: HDR_W];
  assign in_op   = hdr_op(in_hdr);
  assign adv     = !ex_q.valid | out_ready;
  assign uses_rd = (in_op[4:3] == 2'b00) | (in_op == 5'b01001);
  assign stall   = (state_q == RUN) & last_memr_q &
                   ((hdr_rs(in_hdr) == last_dst_q) | (uses_rd & (hdr_rd(in_hdr) == last_dst_q)));
  assign take    = (state_q == RUN) & pending_q & adv;
  assign in_rdy  = rst & !flush & adv & ((state_q == RUN) | (state_q == IMM)) & !stall & !take;
  assign accept  = in_valid & in_rdy;
  // Interrupt entry is resolved in the same cycle, so the PC push issues without a bubble.
  assign state_eff = take ? INT1 : state_q;
  assign src_hdr   = (state_q == IMM) ? first_q : in_hdr;

  always_comb begin
    regs_d = regs_q;
    if (wb_en) regs_d[wb_addr] = wb_data;
  end

  always_comb begin
    rs_val = regs_q[hdr_rs(src_hdr)];
    rd_val = regs_q[hdr_rd(src_hdr)];
`ifdef REG_BYPASS_EN
    if (wb_en && (wb_addr == hdr_rs(src_hdr))) rs_val = wb_data;
    if (wb_en && (wb_addr == hdr_rd(src_hdr))) rd_val = wb_data;
`endif
  end

  always_comb begin
    state_d     = state_q;
    first_d     = first_q;
    pending_d   = pending_q | int_req;
    last_memr_d = last_memr_q;
    last_dst_d  = last_dst_q;
    ex_d        = ex_q;
    int_ack_d   = 1'b0;
    if (flush) begin
      state_d     = RUN;
      ex_d.valid  = 1'b0;
      ex_d.regwr  = 1'b0;
      ex_d.memr   = 1'b0;
      ex_d.memwr  = 1'b0;
      last_memr_d = 1'b0;
      last_dst_d  = '0;
    end else if (adv) begin
      ex_d.valid = 1'b0;
      ex_d.regwr = 1'b0;
      ex_d.memr  = 1'b0;
      ex_d.memwr = 1'b0;
      case (state_eff)
        RUN: begin
          if (accept) begin
            if (in_op[4:3] == 2'b10) begin
              first_d = in_hdr;
              state_d = IMM;
            end else begin
              ex_d = mk_ex(in_op, rs_val, rd_val, '0, hdr_rd(in_hdr));
            end
          end
        end
        IMM: begin
          if (accept) begin
            ex_d    = mk_ex(hdr_op(first_q), rs_val, rd_val, in_instr, hdr_rd(first_q));
            state_d = RUN;
          end
        end
        INT1: begin
          pending_d = 1'b0;
          ex_d      = mk_ex(5'b11100, '0, '0, '0, '0);
          state_d   = INT2;
        end
        INT2: begin
          ex_d      = mk_ex(5'b11101, '0, '0, '0, '0);
          int_ack_d = 1'b1;
          state_d   = RUN;
        end
        default: state_d = RUN;
      endcase
      last_memr_d = ex_d.valid & ex_d.memr;
      last_dst_d  = ex_d.dst;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= RUN;
      first_q     <= '0;
      pending_q   <= 1'b0;
      last_memr_q <= 1'b0;
      last_dst_q  <= '0;
      ex_q        <= '0;
      int_ack_q   <= 1'b0;
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      first_q     <= first_d;
      pending_q   <= pending_d;
      last_memr_q <= last_memr_d;
      last_dst_q  <= last_dst_d;
      ex_q        <= ex_d;
      int_ack_q   <= int_ack_d;
      regs_q      <= regs_d;
    end
  end

  assign in_ready  = in_rdy;
  assign int_ack   = int_ack_q;
  assign out_valid = ex_q.valid;
  assign out_op    = ex_q.op;
  assign out_op1   = ex_q.op1;
  assign out_op2   = ex_q.op2;
  assign out_imm   = ex_q.imm;
  assign out_dst   = ex_q.dst;
  assign out_regwr = ex_q.regwr;
  assign out_memr  = ex_q.memr;
  assign out_memwr = ex_q.memwr;

endmodule

// File: doc/id_decode_pipe.md
Name: id_decode_pipe

Overview:
- Parametrised decode stage for the RISC pipeline: register file, opcode decode, load-use stall and interrupt micro-op sequencing.
- Adds valid/ready handshakes and two-word immediate instructions.
- Sits between the fetch buffer (in_*) and the execute stage (out_*); the write-back port comes from WB.
- All outputs come from a registered ID/EX pipeline register.

Parameters:
- WIDTH, 16, instruction/data word width (>= 5+2*REG_AW)
- NREGS, 8, register count (power of two, >= 2)
- REG_AW, $clog2(NREGS), register address width (derived localparam)

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- in_valid  in  1  fetch word valid
- in_instr  in  WIDTH  fetched word (instruction or immediate)
- in_ready  out  1  decode accepts in_instr this cycle
- flush  in  1  kill in-flight decode and output register
- int_req  in  1  interrupt request, level
- int_ack  out  1  one-cycle pulse when the interrupt sequence is issued
- wb_en  in  1  register write enable
- wb_addr  in  REG_AW  write address
- wb_data  in  WIDTH  write data
- out_valid  out  1  ID/EX register holds a valid op
- out_ready  in  1  EX accepts the op
- out_op  out  5  opcode or micro-op code
- out_op1  out  WIDTH  rs value
- out_op2  out  WIDTH  rd value
- out_imm  out  WIDTH  immediate word (0 if none)
- out_dst  out  REG_AW  destination register
- out_regwr, out_memr, out_memwr  out  1 each  control flags

Behaviour:
- Field layout: opcode=instr[WIDTH-1:WIDTH-5], rs=next REG_AW bits, rd=the following REG_AW bits.
- Decode:
  - 00xxx: ALU, regwr=1
  - 01000: LDD, memr=1, regwr=1
  - 01001: STD, memwr=1
  - other 01xxx: no side effects
  - 10xxx: two-word, regwr=1, imm = next word
  - 11xxx: pass-through, flags 0
- out_dst=rd in every case.
- Reset (rst=0, async): every register file entry 0, FSM=RUN, int pending 0, all outputs 0, in_ready=0 while in reset.
- Advance condition: adv = !out_valid | out_ready. The output register loads only when adv=1; otherwise it holds all fields stable.
- FSM states:
  - RUN: in_valid&in_ready with 10xxx latches the first word and goes to IMM, no output. Any other opcode issues in the same cycle (1-cycle latency to out_valid).
  - IMM: next accepted word becomes out_imm; the op issues; go to RUN.
  - INT1: issue out_op=11100 (push PC), go to INT2.
  - INT2: issue out_op=11101 (push CCR), int_ack=1 for that cycle, go to RUN.
- Interrupt:
  - int_req sets pending; pending is cleared on entry to INT1.
  - INT1 is entered only from RUN with adv=1 and no partial two-word op, taking priority over a new in_instr.
- in_ready = adv & (state==RUN | state==IMM) & !stall & !pending_taken.
- Load-use stall:
  - stall=1 if the last issued op had memr=1 and the current RUN-state instruction reads its out_dst as rs, or as rd for ALU/STD.
  - A stall inserts exactly one bubble (out_valid=0 on the next load) and the instruction issues the cycle after.
  - No stall applies to the immediate word.
- flush (sync, priority over everything except reset):
  - out_valid<=0; FSM<=RUN; a latched first word is discarded; pending is kept; the stall tracker is cleared.
- Register file:
  - Read combinationally; written on posedge when wb_en.
  - A write to the same address as a read in that cycle returns the old value unless REG_BYPASS_EN.
- Simultaneous flush and int_req: the flush wins that cycle; the interrupt is taken on the next eligible cycle.
- Width rules: no arithmetic; values pass unmodified at WIDTH bits.

Optional Feature:
- Macro REG_BYPASS_EN.
- Defined: when wb_en and wb_addr equals the rs/rd read address, the read returns wb_data in the same cycle (write-through).
- Undefined: the read returns the stored value; WB forwarding is left to EX.

Test Plan:
- Reset then wb writes R1=0x0012, R2=0x0034; issue ALU 00001 rs=1 rd=2 -> next cycle out_valid=1, out_op1=0x0012, out_op2=0x0034, out_regwr=1.
- LDM 10000 rd=3 followed by word 0xBEEF -> no output after the first word; after the second, out_imm=0xBEEF, out_dst=3, out_regwr=1; in_ready high in both cycles.
- LDD rd=4, then ALU rs=4 -> exactly one out_valid=0 bubble between them; ALU issues in the following cycle.
- int_req asserted mid two-word op -> the immediate completes, then 11100, then 11101 with int_ack=1 for one cycle, and in_ready=0 for 2 cycles.
- out_ready=0 for 3 cycles with out_valid=1 -> outputs held and in_ready=0; flush during IMM -> out_valid=0, FSM back in RUN, next word decoded as an instruction.
- With REG_BYPASS_EN: wb_en R5=0x7777 in the same cycle as ALU rs=5 is accepted -> out_op1=0x7777; without it -> old R5 value.
